// File: rtl/dbgreg_bridge_if.sv
// Word-wide SoC memory bus between the debug bridge (master) and the fabric (slave).
// A request is held by mem_valid until the single-cycle mem_ready completion.
interface dbgreg_bridge_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dbgreg_bridge.sv
// JTAG debug-word to memory-bus bridge: queues captured DR words in a small FIFO and
// executes them as SETADDR/READ/CTRL commands or data writes on a word-wide bus.
module dbgreg_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     dbgreg_in_i,
  input  logic            dbgreg_strobe_i,
  input  logic            dbgreg_sel_i,
  output logic [31:0]     dbgreg_out_o,
  output logic            busy_o,
  output logic            overflow_o,
  dbgreg_bridge_if.master mem
);
  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [1:0]  OP_SETADDR = 2'b00;
  localparam logic [1:0]  OP_READ    = 2'b01;
  localparam logic [1:0]  OP_CTRL    = 2'b10;

  typedef enum logic {S_IDLE, S_BUS} state_e;

  logic [32:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  state_e        state_q;
  logic [29:0]   addr_q;
  logic          autoinc_q, overflow_q, busy_q, mem_valid_q;
  logic [31:0]   mem_addr_q, mem_wdata_q, dbgreg_out_q;
  logic [3:0]    mem_wstrb_q;

  logic          full, push, drop, pop, head_sel, start_bus, bus_done, ovf_clr, bus_d;
  logic [31:0]   head_word;
  logic [1:0]    head_op;

  // Fullness is judged on the registered count, so a same-cycle pop cannot rescue a push.
  always_comb begin
    full      = (cnt_q == FULL_CNT);
    push      = dbgreg_strobe_i & ~full;
    drop      = dbgreg_strobe_i & full;
    pop       = (state_q == S_IDLE) && (cnt_q != '0);
    {head_sel, head_word} = fifo_q[rptr_q];
    head_op   = head_word[31:30];
    start_bus = pop && (!head_sel || head_op == OP_READ);
    bus_done  = (state_q == S_BUS) && mem.mem_ready;
    ovf_clr   = pop && head_sel && (head_op == OP_CTRL) && head_word[1];
    cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    bus_d     = (state_q == S_IDLE) ? start_bus : !bus_done;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= {dbgreg_sel_i, dbgreg_in_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      autoinc_q    <= 1'b1;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      dbgreg_out_q <= '0;
    end else begin
      busy_q     <= (cnt_d != '0) || bus_d;
      // A new drop wins over a clear landing in the same cycle.
      overflow_q <= drop | (overflow_q & ~ovf_clr);
      case (state_q)
        S_IDLE: begin
          if (start_bus) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {addr_q, 2'b00};
            mem_wstrb_q <= head_sel ? 4'h0 : 4'hF;
            if (!head_sel) mem_wdata_q <= head_word;
            state_q     <= S_BUS;
          end else if (pop) begin
            case (head_op)
              OP_SETADDR: addr_q    <= head_word[29:0];
              OP_CTRL:    autoinc_q <= head_word[0];
              default: ;
            endcase
          end
        end
        S_BUS: begin
          if (mem.mem_ready) begin
            mem_valid_q <= 1'b0;
            if (mem_wstrb_q == 4'h0) dbgreg_out_q <= mem.mem_rdata;
            if (autoinc_q) addr_q <= addr_q + 30'd1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign dbgreg_out_o  = dbgreg_out_q;
  assign busy_o        = busy_q;
  assign overflow_o    = overflow_q;
endmodule

// File: tb/tb_dbgreg_bridge.sv
// Bench for dbgreg_bridge: a bus responder records every request, and a command-level
// model of the debug protocol predicts the ordered list of bus accesses.
module tb_dbgreg_bridge;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        stb, sel;
  logic [31:0] dout;
  logic        busy, ovf;

  dbgreg_bridge_if bif ();

  dbgreg_bridge #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .dbgreg_in_i(din), .dbgreg_strobe_i(stb),
    .dbgreg_sel_i(sel), .dbgreg_out_o(dout), .busy_o(busy), .overflow_o(ovf), .mem(bif)
  );

  always #5 clk = ~clk;

  int vec = 0, miss = 0;

  // command-level reference state
  logic [31:0] m_addr;
  logic        m_auto;
  logic [31:0] m_dout;
  txn_t        exp_q[$];
  txn_t        obs[$];

  // responder controls and observations
  int          lat_cfg = 0;
  bit          hold_ready = 0;
  bit          rdata_fix_en = 0;
  logic [31:0] rdata_fix = '0;
  int          stall_cnt = 0, stab_err = 0, gap_err = 0;
  logic [31:0] dout_before, dout_after;

  initial begin
    txn_t cur;
    bit   waiting;
    int   wcnt;
    bif.mem_ready = 1'b0;
    bif.mem_rdata = '0;
    waiting = 0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bif.mem_ready = 1'b0;
        waiting = 0;
      end else if (bif.mem_ready) begin
        bif.mem_ready = 1'b0;
        waiting = 0;
        dout_after = dout;
        if (bif.mem_valid) gap_err++;
      end else if (bif.mem_valid) begin
        if (!waiting) begin
          waiting = 1;
          cur = '{bif.mem_addr, bif.mem_wdata, rdata_fix_en ? rdata_fix : $urandom, bif.mem_wstrb};
          obs.push_back(cur);
          wcnt = (lat_cfg < 0) ? $urandom_range(3, 0) : lat_cfg;
        end else if (bif.mem_addr !== cur.addr || bif.mem_wdata !== cur.wdata ||
                     bif.mem_wstrb !== cur.wstrb) begin
          stab_err++;
        end
        stall_cnt++;
        if (wcnt == 0) begin
          if (!hold_ready) begin
            bif.mem_ready = 1'b1;
            bif.mem_rdata = cur.rdata;
            dout_before = dout;
          end
        end else wcnt--;
      end
    end
  end

  task automatic model_reset();
    m_addr = '0;
    m_auto = 1'b1;
    m_dout = '0;
    exp_q.delete();
    obs.delete();
  endtask

  // Drive one strobe (called at a negedge) and apply the command to the model.
  task automatic put(input logic s, input logic [31:0] w, input bit modeled = 1);
    din = w;
    sel = s;
    stb = 1'b1;
    if (modeled) begin
      if (!s) begin
        exp_q.push_back('{m_addr, w, 32'h0, 4'hF});
        if (m_auto) m_addr += 32'd4;
      end else begin
        case (w[31:30])
          2'b00: m_addr = {w[29:0], 2'b00};
          2'b01: begin
            exp_q.push_back('{m_addr, 32'h0, 32'h0, 4'h0});
            if (m_auto) m_addr += 32'd4;
          end
          2'b10: m_auto = w[0];
          default: ;
        endcase
      end
    end
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    vec++;
    if (busy !== 1'b0) begin
      miss++;
      $display("FAIL %s_idle_timeout busy=%b after %0d cycles, need 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stb = 1'b0; sel = 1'b0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    vec += 7;
    if (bif.mem_valid !== 1'b0) begin miss++; $display("FAIL rst_valid got %b need 0", bif.mem_valid); end
    if (bif.mem_addr !== 32'h0) begin miss++; $display("FAIL rst_addr got %h need 0", bif.mem_addr); end
    if (bif.mem_wdata !== 32'h0) begin miss++; $display("FAIL rst_wdata got %h need 0", bif.mem_wdata); end
    if (bif.mem_wstrb !== 4'h0) begin miss++; $display("FAIL rst_wstrb got %h need 0", bif.mem_wstrb); end
    if (dout !== 32'h0) begin miss++; $display("FAIL rst_dout got %h need 0", dout); end
    if (busy !== 1'b0) begin miss++; $display("FAIL rst_busy got %b need 0", busy); end
    if (ovf !== 1'b0) begin miss++; $display("FAIL rst_ovf got %b need 0", ovf); end
    rst = 1'b0;
    lat_cfg = 0;
    put(1'b1, 32'h8000_0000);
    put(1'b0, 32'h1111_1111);
    put(1'b0, 32'h2222_2222);
    wait_idle("rst");
    vec++;
    if (obs.size() !== exp_q.size()) begin
      miss++; $display("FAIL rst_txn_count got %0d need %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      vec++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].wstrb !== exp_q[i].wstrb ||
          (exp_q[i].wstrb != 0 && obs[i].wdata !== exp_q[i].wdata)) begin
        miss++;
        $display("FAIL rst_txn%0d got a=%h d=%h s=%h need a=%h d=%h s=%h", i, obs[i].addr,
                 obs[i].wdata, obs[i].wstrb, exp_q[i].addr, exp_q[i].wdata, exp_q[i].wstrb);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_write_burst();
    lat_cfg = 0;
    put(1'b1, 32'h8000_0001);
    put(1'b1, 32'h0000_0400);
    wait_idle("burst_setup");
    put(1'b0, 32'hDEAD_BEEF);
    vec += 2;
    if (bif.mem_valid !== 1'b0) begin miss++; $display("FAIL burst_valid_early got %b need 0", bif.mem_valid); end
    @(negedge clk);
    if (bif.mem_valid !== 1'b1) begin miss++; $display("FAIL burst_valid_latency got %b need 1", bif.mem_valid); end
    put(1'b0, 32'h1234_5678);
    wait_idle("burst");
    vec += 2;
    if (gap_err !== 0) begin miss++; $display("FAIL burst_gap got %0d need 0", gap_err); end
    if (obs.size() !== exp_q.size()) begin
      miss++; $display("FAIL burst_txn_count got %0d need %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      vec++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].wstrb !== exp_q[i].wstrb ||
          (exp_q[i].wstrb != 0 && obs[i].wdata !== exp_q[i].wdata)) begin
        miss++;
        $display("FAIL burst_txn%0d got a=%h d=%h s=%h need a=%h d=%h s=%h", i, obs[i].addr,
                 obs[i].wdata, obs[i].wstrb, exp_q[i].addr, exp_q[i].wdata, exp_q[i].wstrb);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_read_stall();
    logic [31:0] old_dout;
    lat_cfg = 5;
    rdata_fix_en = 1;
    rdata_fix = 32'hCAFE_F00D;
    stab_err = 0;
    put(1'b1, 32'h0000_0010);
    wait_idle("read_setup");
    stall_cnt = 0;
    old_dout = m_dout;
    put(1'b1, 32'h4000_0000);
    wait_idle("read");
    vec += 4;
    if (stall_cnt !== 6) begin miss++; $display("FAIL read_stall_len got %0d need 6", stall_cnt); end
    if (stab_err !== 0) begin miss++; $display("FAIL read_stable got %0d changes need 0", stab_err); end
    if (dout_before !== old_dout) begin miss++; $display("FAIL read_dout_early got %h need %h", dout_before, old_dout); end
    if (dout_after !== 32'hCAFE_F00D) begin miss++; $display("FAIL read_dout got %h need cafef00d", dout_after); end
    rdata_fix_en = 0;
    lat_cfg = 1;
    put(1'b1, 32'h4000_0000);
    wait_idle("read2");
    vec++;
    if (obs.size() !== exp_q.size()) begin
      miss++; $display("FAIL read_txn_count got %0d need %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      vec++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].wstrb !== exp_q[i].wstrb) begin
        miss++;
        $display("FAIL read_txn%0d got a=%h s=%h need a=%h s=%h", i, obs[i].addr,
                 obs[i].wstrb, exp_q[i].addr, exp_q[i].wstrb);
      end
      if (exp_q[i].wstrb == 4'h0) m_dout = obs[i].rdata;
    end
    vec++;
    if (dout !== m_dout) begin miss++; $display("FAIL read_dout_last got %h need %h", dout, m_dout); end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    lat_cfg = 0;
    hold_ready = 1;
    for (int k = 0; k < 5; k++) put(1'b0, $urandom);
    vec++;
    if (ovf !== 1'b0) begin miss++; $display("FAIL ovf_early got %b need 0", ovf); end
    put(1'b0, 32'hBAD0_BAD0, 0);
    vec += 3;
    if (ovf !== 1'b1) begin miss++; $display("FAIL ovf_set got %b need 1", ovf); end
    if (busy !== 1'b1) begin miss++; $display("FAIL ovf_busy got %b need 1", busy); end
    if (bif.mem_valid !== 1'b1) begin miss++; $display("FAIL ovf_inflight got %b need 1", bif.mem_valid); end
    hold_ready = 0;
    wait_idle("ovf_drain");
    vec++;
    if (ovf !== 1'b1) begin miss++; $display("FAIL ovf_sticky got %b need 1", ovf); end
    put(1'b1, 32'h8000_0002);
    wait_idle("ovf_clr");
    vec += 2;
    if (ovf !== 1'b0) begin miss++; $display("FAIL ovf_clear got %b need 0", ovf); end
    if (obs.size() !== exp_q.size()) begin
      miss++; $display("FAIL ovf_txn_count got %0d need %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      vec++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].wstrb !== exp_q[i].wstrb ||
          obs[i].wdata !== exp_q[i].wdata) begin
        miss++;
        $display("FAIL ovf_txn%0d got a=%h d=%h s=%h need a=%h d=%h s=%h", i, obs[i].addr,
                 obs[i].wdata, obs[i].wstrb, exp_q[i].addr, exp_q[i].wdata, exp_q[i].wstrb);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    lat_cfg = 2;
    put(1'b1, 32'h8000_0001);
    put(1'b1, 32'h3FFF_FFFF);
    put(1'b0, 32'hA5A5_0001);
    put(1'b0, 32'hA5A5_0002);
    wait_idle("wrap");
    vec++;
    if (obs.size() !== exp_q.size()) begin
      miss++; $display("FAIL wrap_txn_count got %0d need %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      vec++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].wdata !== exp_q[i].wdata) begin
        miss++;
        $display("FAIL wrap_txn%0d got a=%h d=%h need a=%h d=%h", i, obs[i].addr,
                 obs[i].wdata, exp_q[i].addr, exp_q[i].wdata);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int n;
    lat_cfg = -1;
    stab_err = 0;
    gap_err = 0;
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(4, 1);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(5, 0))
          0, 1:    put(1'b0, $urandom);
          2:       put(1'b1, {2'b00, 30'($urandom)});
          3:       put(1'b1, {2'b01, 30'($urandom)});
          4:       put(1'b1, {2'b10, 30'($urandom)});
          default: put(1'b1, {2'b11, 30'($urandom)});
        endcase
        if ($urandom_range(1, 0) == 1) @(negedge clk);
      end
      wait_idle("rand");
    end
    vec += 4;
    if (obs.size() !== exp_q.size()) begin
      miss++; $display("FAIL rand_txn_count got %0d need %0d", obs.size(), exp_q.size());
    end
    if (stab_err !== 0) begin miss++; $display("FAIL rand_stable got %0d changes need 0", stab_err); end
    if (gap_err !== 0) begin miss++; $display("FAIL rand_gap got %0d need 0", gap_err); end
    if (ovf !== 1'b0) begin miss++; $display("FAIL rand_ovf got %b need 0", ovf); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      vec++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].wstrb !== exp_q[i].wstrb ||
          (exp_q[i].wstrb != 0 && obs[i].wdata !== exp_q[i].wdata)) begin
        miss++;
        $display("FAIL rand_txn%0d got a=%h d=%h s=%h need a=%h d=%h s=%h", i, obs[i].addr,
                 obs[i].wdata, obs[i].wstrb, exp_q[i].addr, exp_q[i].wdata, exp_q[i].wstrb);
      end
      if (exp_q[i].wstrb == 4'h0) m_dout = obs[i].rdata;
    end
    vec++;
    if (dout !== m_dout) begin miss++; $display("FAIL rand_dout got %h need %h", dout, m_dout); end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    lat_cfg = 0;
    hold_ready = 1;
    put(1'b0, 32'h0000_0001);
    put(1'b0, 32'h0000_0002);
    put(1'b0, 32'h0000_0003);
    repeat (2) @(negedge clk);
    vec += 2;
    if (bif.mem_valid !== 1'b1) begin miss++; $display("FAIL mid_inflight got %b need 1", bif.mem_valid); end
    if (busy !== 1'b1) begin miss++; $display("FAIL mid_busy got %b need 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if (bif.mem_valid !== 1'b0) begin miss++; $display("FAIL mid_valid_drop got %b need 0", bif.mem_valid); end
    rst = 1'b0;
    hold_ready = 0;
    model_reset();
    repeat (20) @(negedge clk);
    vec += 5;
    if (obs.size() !== 0) begin miss++; $display("FAIL mid_no_txn got %0d txns need 0", obs.size()); end
    if (busy !== 1'b0) begin miss++; $display("FAIL mid_busy_after got %b need 0", busy); end
    if (bif.mem_addr !== 32'h0) begin miss++; $display("FAIL mid_addr got %h need 0", bif.mem_addr); end
    if (dout !== 32'h0) begin miss++; $display("FAIL mid_dout got %h need 0", dout); end
    if (ovf !== 1'b0) begin miss++; $display("FAIL mid_ovf got %b need 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_stall();
    test_overflow();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
